// File: rtl/cargador_bloque.sv
// cargador_bloque: collects a 13-byte frame (block bytes + target), drives the
// mining engine until it finishes or the cycle budget runs out, then offers the
// result downstream through a valid/ready handshake.
module cargador_bloque #(
    parameter int unsigned N_BYTES      = 12,
    parameter int unsigned ANCHO_BOUNTY = 124,
    parameter int unsigned TIEMPO_MAX   = 20000
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic [7:0]                i_byte_entrada,
    input  logic                      i_byte_valido,
    output logic                      o_byte_listo,
    output logic [8*N_BYTES-1:0]      o_bloque_datos,
    output logic [7:0]                o_target,
    output logic                      o_inicio,
    input  logic                      i_terminado,
    input  logic [ANCHO_BOUNTY-1:0]   i_bounty,
    output logic [ANCHO_BOUNTY-1:0]   o_resultado,
    output logic                      o_resultado_valido,
    input  logic                      i_resultado_listo,
    output logic                      o_timeout
);

    localparam int unsigned ANCHO_BYTES  = $clog2(N_BYTES + 1);
    localparam int unsigned ANCHO_CICLOS = $clog2(TIEMPO_MAX);
    localparam logic [ANCHO_BYTES-1:0]  ULTIMO_BYTE  = ANCHO_BYTES'(N_BYTES);
    localparam logic [ANCHO_CICLOS-1:0] ULTIMO_CICLO = ANCHO_CICLOS'(TIEMPO_MAX - 1);

    typedef enum logic [1:0] {
        StRecibir  = 2'd0,
        StMinar    = 2'd1,
        StEntregar = 2'd2
    } estado_t;

    estado_t                   r_estado,    w_estado_d;
    logic [ANCHO_BYTES-1:0]    r_cuenta,    w_cuenta_d;
    logic [ANCHO_CICLOS-1:0]   r_ciclos,    w_ciclos_d;
    logic [8*N_BYTES-1:0]      r_sombra,    w_sombra_d;
    logic [8*N_BYTES-1:0]      r_bloque,    w_bloque_d;
    logic [7:0]                r_target,    w_target_d;
    logic                      r_inicio,    w_inicio_d;
    logic [ANCHO_BOUNTY-1:0]   r_resultado, w_resultado_d;
    logic                      r_valido,    w_valido_d;
    logic                      r_timeout,   w_timeout_d;

    logic                      w_transferencia;
    logic [8*N_BYTES+7:0]      w_desplazada;

    assign o_byte_listo    = (r_estado == StRecibir) & ~i_reset;
    assign w_transferencia = i_byte_valido & o_byte_listo;
    // New byte enters at the LSB so the first byte ends up in the MSB lane.
    assign w_desplazada    = {r_sombra, i_byte_entrada};

    // Next-state and next-value logic for the frame/mine/deliver sequence.
    always_comb begin
        w_estado_d    = r_estado;
        w_cuenta_d    = r_cuenta;
        w_ciclos_d    = r_ciclos;
        w_sombra_d    = r_sombra;
        w_bloque_d    = r_bloque;
        w_target_d    = r_target;
        w_inicio_d    = r_inicio;
        w_resultado_d = r_resultado;
        w_valido_d    = r_valido;
        w_timeout_d   = r_timeout;

        unique case (r_estado)
            StRecibir: begin
                if (w_transferencia) begin
                    if (r_cuenta == ULTIMO_BYTE) begin
                        // Target byte goes straight to the output alongside the block shadow.
                        w_bloque_d = r_sombra;
                        w_target_d = i_byte_entrada;
                        w_ciclos_d = '0;
                        w_inicio_d = 1'b1;
                        w_estado_d = StMinar;
                    end else begin
                        w_sombra_d = w_desplazada[8*N_BYTES-1:0];
                        w_cuenta_d = r_cuenta + ANCHO_BYTES'(1);
                    end
                end
            end
            StMinar: begin
                w_ciclos_d = r_ciclos + ANCHO_CICLOS'(1);
                // Engine completion takes priority over the budget expiring.
                if (i_terminado) begin
                    w_resultado_d = i_bounty;
                    w_timeout_d   = 1'b0;
                    w_inicio_d    = 1'b0;
                    w_valido_d    = 1'b1;
                    w_estado_d    = StEntregar;
                end else if (r_ciclos == ULTIMO_CICLO) begin
                    w_resultado_d = '0;
                    w_timeout_d   = 1'b1;
                    w_inicio_d    = 1'b0;
                    w_valido_d    = 1'b1;
                    w_estado_d    = StEntregar;
                end
            end
            StEntregar: begin
                if (i_resultado_listo) begin
                    w_valido_d = 1'b0;
                    w_cuenta_d = '0;
                    w_estado_d = StRecibir;
                end
            end
            default: begin
                w_estado_d = StRecibir;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_estado    <= StRecibir;
            r_cuenta    <= '0;
            r_ciclos    <= '0;
            r_sombra    <= '0;
            r_bloque    <= '0;
            r_target    <= '0;
            r_inicio    <= 1'b0;
            r_resultado <= '0;
            r_valido    <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_estado    <= w_estado_d;
            r_cuenta    <= w_cuenta_d;
            r_ciclos    <= w_ciclos_d;
            r_sombra    <= w_sombra_d;
            r_bloque    <= w_bloque_d;
            r_target    <= w_target_d;
            r_inicio    <= w_inicio_d;
            r_resultado <= w_resultado_d;
            r_valido    <= w_valido_d;
            r_timeout   <= w_timeout_d;
        end
    end

    assign o_bloque_datos     = r_bloque;
    assign o_target           = r_target;
    assign o_inicio           = r_inicio;
    assign o_resultado        = r_resultado;
    assign o_resultado_valido = r_valido;
    assign o_timeout          = r_timeout;

endmodule

// File: tb/tb_cargador_bloque.sv
// Bench for cargador_bloque: table of frame transactions, reset corner cases,
// then randomized frames checked against a frame-level reference model.
module tb_cargador_bloque;

    localparam int unsigned TMAX = 100;

    logic          clk = 1'b0;
    logic          reset;
    logic [7:0]    byte_entrada;
    logic          byte_valido;
    logic          byte_listo;
    logic [95:0]   bloque_datos;
    logic [7:0]    target;
    logic          inicio;
    logic          terminado;
    logic [123:0]  bounty;
    logic [123:0]  resultado;
    logic          resultado_valido;
    logic          resultado_listo;
    logic          timeout;

    int n_vec  = 0;
    int n_miss = 0;

    logic [95:0] prev_blk;
    logic [7:0]  prev_tgt;

    cargador_bloque #(
        .N_BYTES      (12),
        .ANCHO_BOUNTY (124),
        .TIEMPO_MAX   (TMAX)
    ) dut (
        .i_clk              (clk),
        .i_reset            (reset),
        .i_byte_entrada     (byte_entrada),
        .i_byte_valido      (byte_valido),
        .o_byte_listo       (byte_listo),
        .o_bloque_datos     (bloque_datos),
        .o_target           (target),
        .o_inicio           (inicio),
        .i_terminado        (terminado),
        .i_bounty           (bounty),
        .o_resultado        (resultado),
        .o_resultado_valido (resultado_valido),
        .i_resultado_listo  (resultado_listo),
        .o_timeout          (timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [95:0]  blk;
        logic [7:0]   tgt;
        int           gap;    // 0 none, 1 gap before every byte after the first, 2 random
        int           delay;  // MINAR cycle index at which terminado is raised
        logic [123:0] bty;
        int           hold;   // cycles resultado_listo stays low
        logic [123:0] e_res;
        logic         e_to;
    } vec_t;

    vec_t tbl[7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [123:0] rnd124();
        logic [127:0] t;
        t = {$urandom, $urandom, $urandom, $urandom};
        return t[123:0];
    endfunction

    task automatic chk_zero(input string tag);
        chk({tag, "_bloque"}, bloque_datos, 0);
        chk({tag, "_target"}, target, 0);
        chk({tag, "_inicio"}, inicio, 0);
        chk({tag, "_resultado"}, resultado, 0);
        chk({tag, "_valido"}, resultado_valido, 0);
        chk({tag, "_timeout"}, timeout, 0);
        chk({tag, "_byte_listo"}, byte_listo, 1);
    endtask

    task automatic send_frame(input logic [95:0] blk, input logic [7:0] tgt, input int gap);
        logic [7:0] b;
        bit         do_gap;
        for (int i = 0; i < 13; i++) begin
            b = (i < 12) ? blk[95-8*i -: 8] : tgt;
            do_gap = (gap == 1 && i > 0) || (gap == 2 && $urandom_range(0, 2) == 0);
            if (do_gap) begin
                byte_valido  = 1'b0;
                byte_entrada = 8'($urandom);
                tick();
                chk("inicio_in_gap", inicio, 0);
            end
            byte_valido  = 1'b1;
            byte_entrada = b;
            chk("byte_listo_recibir", byte_listo, 1);
            if (i == 6) begin
                chk("bloque_held_prev", bloque_datos, prev_blk);
                chk("target_held_prev", target, prev_tgt);
            end
            tick();
            if (i < 12) chk("inicio_early", inicio, 0);
        end
        // Junk bytes stay valid through MINAR; they must be ignored.
        byte_valido  = 1'b1;
        byte_entrada = 8'($urandom);
        chk("inicio_after_last", inicio, 1);
        chk("byte_listo_minar", byte_listo, 0);
        chk("bloque_datos", bloque_datos, blk);
        chk("target", target, tgt);
        chk("valido_minar", resultado_valido, 0);
        prev_blk = blk;
        prev_tgt = tgt;
    endtask

    task automatic mine(input int d, input logic [123:0] bty, input logic [123:0] e_res,
                        input logic e_to);
        for (int c = 0; c < int'(TMAX); c++) begin
            chk("inicio_held", inicio, 1);
            if (c == d) begin
                terminado = 1'b1;
                bounty    = bty;
            end else begin
                bounty    = rnd124();
            end
            tick();
            terminado = 1'b0;
            if (c == d) break;
        end
        chk("inicio_done", inicio, 0);
        chk("valido_done", resultado_valido, 1);
        chk("resultado", resultado, e_res);
        chk("timeout", timeout, e_to);
        chk("bloque_during_entregar", bloque_datos, prev_blk);
    endtask

    task automatic deliver(input int hold, input logic [123:0] e_res, input logic e_to);
        for (int k = 0; k < hold; k++) begin
            resultado_listo = 1'b0;
            terminado       = 1'b1;  // must be ignored outside MINAR
            bounty          = rnd124();
            tick();
            chk("valido_hold", resultado_valido, 1);
            chk("resultado_hold", resultado, e_res);
            chk("timeout_hold", timeout, e_to);
        end
        terminado       = 1'b0;
        resultado_listo = 1'b1;
        tick();
        resultado_listo = 1'b0;
        byte_valido     = 1'b0;
        chk("valido_released", resultado_valido, 0);
        chk("byte_listo_back", byte_listo, 1);
        chk("resultado_kept", resultado, e_res);
        chk("timeout_kept", timeout, e_to);
        chk("inicio_idle", inicio, 0);
    endtask

    task automatic run_vec(input vec_t v);
        send_frame(v.blk, v.tgt, v.gap);
        mine(v.delay, v.bty, v.e_res, v.e_to);
        deliver(v.hold, v.e_res, v.e_to);
    endtask

    initial begin
        vec_t         v;
        logic [95:0]  blk;

        tbl[0] = '{96'h397d9f2f40ca9e6c6b1f3324, 8'h0a, 0, 50, 124'hABC, 5, 124'hABC, 1'b0};
        tbl[1] = '{96'h397d9f2f40ca9e6c6b1f3324, 8'h0a, 0, 1000, 124'h5555, 0, 124'h0, 1'b1};
        tbl[2] = '{96'h397d9f2f40ca9e6c6b1f3324, 8'h0a, 1, 7, 124'h123456789, 1,
                   124'h123456789, 1'b0};
        tbl[3] = '{96'h0102030405060708090a0b0c, 8'hff, 0, 0, {124{1'b1}}, 2, {124{1'b1}}, 1'b0};
        tbl[4] = '{{96{1'b1}}, 8'h00, 2, 99, 124'hDEADBEEF, 0, 124'hDEADBEEF, 1'b0};
        tbl[5] = '{96'h0, 8'h80, 0, 98, 124'h1, 3, 124'h1, 1'b0};
        tbl[6] = '{96'ha5a5a5a5a5a5a5a5a5a5a5a5, 8'h5a, 1, 100, 124'h77, 1, 124'h0, 1'b1};

        reset           = 1'b1;
        byte_entrada    = 8'h00;
        byte_valido     = 1'b0;
        terminado       = 1'b0;
        bounty          = '0;
        resultado_listo = 1'b0;
        prev_blk        = '0;
        prev_tgt        = '0;

        tick();
        tick();
        chk("byte_listo_in_reset", byte_listo, 0);
        reset = 1'b0;
        #1;
        chk_zero("reset");

        foreach (tbl[i]) run_vec(tbl[i]);

        // Reset after byte 6 discards the partial frame.
        for (int i = 0; i < 6; i++) begin
            byte_valido  = 1'b1;
            byte_entrada = 8'(8'h11 * (i + 1));
            tick();
        end
        reset = 1'b1;
        #1;
        chk("byte_listo_reset_mid", byte_listo, 0);
        tick();
        reset       = 1'b0;
        byte_valido = 1'b0;
        #1;
        chk_zero("rst_mid_frame");
        prev_blk = '0;
        prev_tgt = '0;
        v = '{96'hc0ffee112233445566778899, 8'h42, 0, 3, 124'hBEE, 1, 124'hBEE, 1'b0};
        run_vec(v);

        // Reset mid-MINAR.
        send_frame(96'h0badf00d0badf00d0badf00d, 8'h99, 0);
        for (int c = 0; c < 10; c++) tick();
        chk("inicio_before_reset", inicio, 1);
        reset = 1'b1;
        tick();
        reset       = 1'b0;
        byte_valido = 1'b0;
        #1;
        chk_zero("rst_mid_minar");
        prev_blk = '0;
        prev_tgt = '0;
        v = '{96'h000102030405060708090a0b, 8'h01, 2, 20, 124'hF00D, 0, 124'hF00D, 1'b0};
        run_vec(v);

        // Randomized frames against a frame-level model.
        for (int n = 0; n < 20; n++) begin
            blk = '0;
            for (int i = 0; i < 12; i++) blk = (blk << 8) | 96'($urandom_range(0, 255));
            v.blk   = blk;
            v.tgt   = 8'($urandom_range(0, 255));
            v.gap   = 2;
            v.delay = $urandom_range(0, 130);
            v.bty   = rnd124();
            v.hold  = $urandom_range(0, 4);
            v.e_to  = (v.delay >= int'(TMAX));
            v.e_res = v.e_to ? 124'h0 : v.bty;
            run_vec(v);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
